// File: rtl/ristretto_dmem_responder.sv
// ristretto_dmem_responder
// Data-memory responder for the LSU read and write ports. Requests are accepted
// one at a time, answered after LatencyCycles, and served from a single-port
// word array with byte-lane alignment taken from addr[1:0].
// Optional feature macro: RISTRETTO_DMEM_ERR_EN adds per-port out-of-range error
// outputs. Without it, addresses wrap modulo DepthWords*4.
module ristretto_dmem_responder #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int DepthWords    = 1024,
    parameter int LatencyCycles = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    dmem_rdata_req_i,
    input  logic [AddressWidth-1:0] dmem_rdata_addr_i,
    input  logic [DataWidth/8-1:0]  dmem_rdata_strb_i,
    output logic                    dmem_rdata_ready_o,
    output logic                    dmem_rdata_valid_o,
    output logic [DataWidth-1:0]    dmem_rdata_data_o,
    input  logic                    dmem_wdata_req_i,
    input  logic [AddressWidth-1:0] dmem_wdata_addr_i,
    input  logic [DataWidth/8-1:0]  dmem_wdata_strb_i,
    input  logic [DataWidth-1:0]    dmem_wdata_data_i,
    output logic                    dmem_wdata_ready_o,
    output logic                    dmem_wdata_valid_o
`ifdef RISTRETTO_DMEM_ERR_EN
    ,
    output logic                    dmem_rdata_err_o,
    output logic                    dmem_wdata_err_o
`endif
);

    localparam int StrbW = DataWidth / 8;
    localparam int IdxW  = $clog2(DepthWords);
    localparam int CntW  = (LatencyCycles > 1) ? $clog2(LatencyCycles) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    // Expand each strobe bit into a full byte of mask.
    function automatic logic [DataWidth-1:0] lane_mask(input logic [StrbW-1:0] strb);
        logic [DataWidth-1:0] m;
        m = '0;
        for (int i = 0; i < StrbW; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // Right-align the addressed lanes of a word and zero the unused upper lanes.
    function automatic logic [DataWidth-1:0] read_align(input logic [DataWidth-1:0] word,
                                                        input logic [1:0]           off,
                                                        input logic [StrbW-1:0]     strb);
        return (word >> {off, 3'b000}) & lane_mask(strb);
    endfunction

    // Byte enables for a write; lanes shifted past the top of the word fall off.
    function automatic logic [StrbW-1:0] write_be(input logic [StrbW-1:0] strb,
                                                  input logic [1:0]       off);
        return strb << off;
    endfunction

    // Move low-aligned write data up to its byte offset.
    function automatic logic [DataWidth-1:0] write_align(input logic [DataWidth-1:0] data,
                                                         input logic [1:0]           off);
        return data << {off, 3'b000};
    endfunction

    logic [DataWidth-1:0]    mem [DepthWords];

    logic [1:0]              state;
    logic [CntW-1:0]         cnt;
    logic                    sel_rd;
    logic [AddressWidth-1:0] addr_q;
    logic [StrbW-1:0]        strb_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [IdxW-1:0]         idx;
    logic                    enter_resp;
    logic                    oor;

    assign idx        = addr_q[IdxW+1:2];
    assign enter_resp = ((state == ACK) && (LatencyCycles == 1)) ||
                        ((state == WAIT) && (cnt == CntW'(1)));

`ifdef RISTRETTO_DMEM_ERR_EN
    assign oor = |addr_q[AddressWidth-1:IdxW+2];
`else
    // Upper address bits are ignored so the array simply wraps.
    logic unused_hi_addr;
    assign unused_hi_addr = ^addr_q[AddressWidth-1:IdxW+2];
    assign oor            = 1'b0;
`endif

    // Control FSM and registered handshake/response outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state              <= IDLE;
            cnt                <= '0;
            sel_rd             <= 1'b0;
            dmem_rdata_ready_o <= 1'b0;
            dmem_rdata_valid_o <= 1'b0;
            dmem_rdata_data_o  <= '0;
            dmem_wdata_ready_o <= 1'b0;
            dmem_wdata_valid_o <= 1'b0;
`ifdef RISTRETTO_DMEM_ERR_EN
            dmem_rdata_err_o   <= 1'b0;
            dmem_wdata_err_o   <= 1'b0;
`endif
        end else begin
            dmem_rdata_ready_o <= 1'b0;
            dmem_rdata_valid_o <= 1'b0;
            dmem_wdata_ready_o <= 1'b0;
            dmem_wdata_valid_o <= 1'b0;
`ifdef RISTRETTO_DMEM_ERR_EN
            dmem_rdata_err_o   <= 1'b0;
            dmem_wdata_err_o   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (dmem_rdata_req_i) begin
                        sel_rd             <= 1'b1;
                        dmem_rdata_ready_o <= 1'b1;
                        state              <= ACK;
                    end else if (dmem_wdata_req_i) begin
                        sel_rd             <= 1'b0;
                        dmem_wdata_ready_o <= 1'b1;
                        state              <= ACK;
                    end
                end
                ACK: begin
                    if (LatencyCycles == 1) begin
                        state <= RESP;
                    end else begin
                        cnt   <= CntW'(LatencyCycles - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CntW'(1)) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CntW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (enter_resp) begin
                if (sel_rd) begin
                    dmem_rdata_valid_o <= 1'b1;
                    dmem_rdata_data_o  <= oor ? '0 : read_align(mem[idx], addr_q[1:0], strb_q);
`ifdef RISTRETTO_DMEM_ERR_EN
                    dmem_rdata_err_o   <= oor;
`endif
                end else begin
                    dmem_wdata_valid_o <= 1'b1;
`ifdef RISTRETTO_DMEM_ERR_EN
                    dmem_wdata_err_o   <= oor;
`endif
                end
            end
        end
    end

    // Request capture; only the winning port's fields are latched in IDLE.
    always_ff @(posedge clk_i) begin
        if (state == IDLE) begin
            if (dmem_rdata_req_i) begin
                addr_q <= dmem_rdata_addr_i;
                strb_q <= dmem_rdata_strb_i;
            end else if (dmem_wdata_req_i) begin
                addr_q  <= dmem_wdata_addr_i;
                strb_q  <= dmem_wdata_strb_i;
                wdata_q <= dmem_wdata_data_i;
            end
        end
    end

    // Write commit on the edge that closes RESP; a reset on that edge cancels it.
    always_ff @(posedge clk_i) begin
        if (rstn_i && (state == RESP) && !sel_rd && !oor) begin
            for (int i = 0; i < StrbW; i++) begin
                if (write_be(strb_q, addr_q[1:0])[i]) begin
                    mem[idx][8*i +: 8] <= write_align(wdata_q, addr_q[1:0])[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ristretto_dmem_responder.sv
// Directed bench for ristretto_dmem_responder: instance 0 uses LatencyCycles=1,
// instance 1 uses LatencyCycles=4. Table rows drive single transactions on
// instance 0; hand-written sequences cover read/write contention and reset
// during a pending write.
module tb_ristretto_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rstn, rreq, wreq, rrdy, rvld, wrdy, wvld;
    logic [31:0] raddr [2];
    logic [31:0] waddr [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic [3:0]  rstrb [2];
    logic [3:0]  wstrb [2];
`ifdef RISTRETTO_DMEM_ERR_EN
    logic [1:0]  rerr, werr;
`endif

    int checks = 0;
    int errors = 0;

    ristretto_dmem_responder #(.LatencyCycles(1)) u_lat1 (
        .clk_i(clk), .rstn_i(rstn[0]),
        .dmem_rdata_req_i(rreq[0]), .dmem_rdata_addr_i(raddr[0]), .dmem_rdata_strb_i(rstrb[0]),
        .dmem_rdata_ready_o(rrdy[0]), .dmem_rdata_valid_o(rvld[0]), .dmem_rdata_data_o(rdat[0]),
        .dmem_wdata_req_i(wreq[0]), .dmem_wdata_addr_i(waddr[0]), .dmem_wdata_strb_i(wstrb[0]),
        .dmem_wdata_data_i(wdat[0]), .dmem_wdata_ready_o(wrdy[0]), .dmem_wdata_valid_o(wvld[0])
`ifdef RISTRETTO_DMEM_ERR_EN
        , .dmem_rdata_err_o(rerr[0]), .dmem_wdata_err_o(werr[0])
`endif
    );

    ristretto_dmem_responder #(.LatencyCycles(4)) u_lat4 (
        .clk_i(clk), .rstn_i(rstn[1]),
        .dmem_rdata_req_i(rreq[1]), .dmem_rdata_addr_i(raddr[1]), .dmem_rdata_strb_i(rstrb[1]),
        .dmem_rdata_ready_o(rrdy[1]), .dmem_rdata_valid_o(rvld[1]), .dmem_rdata_data_o(rdat[1]),
        .dmem_wdata_req_i(wreq[1]), .dmem_wdata_addr_i(waddr[1]), .dmem_wdata_strb_i(wstrb[1]),
        .dmem_wdata_data_i(wdat[1]), .dmem_wdata_ready_o(wrdy[1]), .dmem_wdata_valid_o(wvld[1])
`ifdef RISTRETTO_DMEM_ERR_EN
        , .dmem_rdata_err_o(rerr[1]), .dmem_wdata_err_o(werr[1])
`endif
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          eerr;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on instance inst; checks ready/valid timing and pulse widths.
    task automatic txn(input int inst, input bit wr, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        int lat, rc, vc;
        logic rdy, vld;
        lat = (inst == 1) ? 4 : 1;
        rc  = 0;
        vc  = 0;
        rd  = '0;
        er  = 1'b0;
        @(posedge clk); #1;
        if (wr) begin
            wreq[inst] = 1'b1; waddr[inst] = a; wstrb[inst] = s; wdat[inst] = d;
        end else begin
            rreq[inst] = 1'b1; raddr[inst] = a; rstrb[inst] = s;
        end
        for (int i = 1; i <= 8 && rc == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            rdy = wr ? wrdy[inst] : rrdy[inst];
            if (rdy) rc = i;
        end
        chk($sformatf("i%0d_ready_latency", inst), rc, 1);
        @(posedge clk); #1;
        wreq[inst] = 1'b0;
        rreq[inst] = 1'b0;
        for (int j = rc + 1; j <= rc + 30 && vc == 0; j++) begin
            @(negedge clk);
            if (j == rc + 1) chk($sformatf("i%0d_ready_pulse", inst), wr ? wrdy[inst] : rrdy[inst], 0);
            vld = wr ? wvld[inst] : rvld[inst];
            if (vld) begin
                vc = j;
                rd = rdat[inst];
`ifdef RISTRETTO_DMEM_ERR_EN
                er = wr ? werr[inst] : rerr[inst];
`endif
            end else begin
                @(posedge clk);
            end
        end
        chk($sformatf("i%0d_valid_latency", inst), vc, 1 + lat);
        @(negedge clk);
        chk($sformatf("i%0d_valid_pulse", inst), wr ? wvld[inst] : rvld[inst], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [3:0]  pat;
        logic [3:0]  exp_pat [6];
        logic        seen;

        rstn = 2'b00; rreq = 2'b00; wreq = 2'b00;
        for (int k = 0; k < 2; k++) begin
            raddr[k] = '0; waddr[k] = '0; wdat[k] = '0; rstrb[k] = '0; wstrb[k] = '0;
        end

        tbl[0]  = '{1'b1, 32'h10,   4'hF, 32'hAABBCCDD, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   4'hF, 32'h0,        32'hAABBCCDD, 1'b0};
        tbl[2]  = '{1'b0, 32'h11,   4'h1, 32'h0,        32'h000000CC, 1'b0};
        tbl[3]  = '{1'b0, 32'h12,   4'h3, 32'h0,        32'h0000AABB, 1'b0};
        tbl[4]  = '{1'b1, 32'h13,   4'h1, 32'h00000055, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 32'h10,   4'hF, 32'h0,        32'h55BBCCDD, 1'b0};
        tbl[6]  = '{1'b1, 32'h10,   4'h3, 32'h00001234, 32'h0,        1'b0};
        tbl[7]  = '{1'b0, 32'h10,   4'hF, 32'h0,        32'h55BB1234, 1'b0};
        tbl[8]  = '{1'b0, 32'h13,   4'h3, 32'h0,        32'h00000055, 1'b0};
        tbl[9]  = '{1'b1, 32'h14,   4'hF, 32'h11223344, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'h17,   4'h3, 32'h0000BEEF, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'h14,   4'hF, 32'h0,        32'hEF223344, 1'b0};
        tbl[12] = '{1'b1, 32'h0,    4'hF, 32'hCAFEF00D, 32'h0,        1'b0};
`ifdef RISTRETTO_DMEM_ERR_EN
        tbl[13] = '{1'b0, 32'h1000, 4'hF, 32'h0,        32'h00000000, 1'b1};
        tbl[14] = '{1'b1, 32'h1000, 4'hF, 32'h0BADBEEF, 32'h0,        1'b1};
        tbl[15] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
`else
        tbl[13] = '{1'b0, 32'h1000, 4'hF, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[14] = '{1'b1, 32'h1000, 4'hF, 32'h0BADBEEF, 32'h0,        1'b0};
        tbl[15] = '{1'b0, 32'h0,    4'hF, 32'h0,        32'h0BADBEEF, 1'b0};
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("i%0d_reset_rready", k), rrdy[k], 0);
            chk($sformatf("i%0d_reset_rvalid", k), rvld[k], 0);
            chk($sformatf("i%0d_reset_wready", k), wrdy[k], 0);
            chk($sformatf("i%0d_reset_wvalid", k), wvld[k], 0);
            chk($sformatf("i%0d_reset_rdata", k), rdat[k], 0);
        end
        @(posedge clk); #1;
        rstn = 2'b11;

        for (int i = 0; i < 16; i++) begin
            txn(0, tbl[i].wr, tbl[i].addr, tbl[i].strb, tbl[i].wd, rd, er);
            if (!tbl[i].wr) chk($sformatf("row%0d_rdata", i), rd, tbl[i].exp);
`ifdef RISTRETTO_DMEM_ERR_EN
            chk($sformatf("row%0d_err", i), er, tbl[i].eerr);
`endif
        end

        // Read and write requested together: read first, write after IDLE.
        exp_pat[0] = 4'b1000; exp_pat[1] = 4'b0100; exp_pat[2] = 4'b0000;
        exp_pat[3] = 4'b0010; exp_pat[4] = 4'b0001; exp_pat[5] = 4'b0000;
        @(posedge clk); #1;
        rreq[0] = 1'b1; raddr[0] = 32'h10; rstrb[0] = 4'hF;
        wreq[0] = 1'b1; waddr[0] = 32'h18; wstrb[0] = 4'hF; wdat[0] = 32'h77777777;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) rreq[0] = 1'b0;
            if (c == 5) wreq[0] = 1'b0;
            @(negedge clk);
            pat = {rrdy[0], rvld[0], wrdy[0], wvld[0]};
            chk($sformatf("both_cycle%0d_pulses", c), pat, exp_pat[c-1]);
            if (c == 2) chk("both_rdata", rdat[0], 32'h55BB1234);
        end
        txn(0, 1'b0, 32'h18, 4'hF, 32'h0, rd, er);
        chk("both_write_landed", rd, 32'h77777777);

        // LatencyCycles=4: reset during WAIT of a write abandons it.
        txn(1, 1'b1, 32'h20, 4'hF, 32'h01020304, rd, er);
        @(posedge clk); #1;
        wreq[1] = 1'b1; waddr[1] = 32'h20; wstrb[1] = 4'hF; wdat[1] = 32'hDEADBEEF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat4_wready", wrdy[1], 1);
        @(posedge clk); #1;
        wreq[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        @(negedge clk);
        chk("rst_wready", wrdy[1], 0);
        chk("rst_wvalid", wvld[1], 0);
        chk("rst_rready", rrdy[1], 0);
        chk("rst_rvalid", rvld[1], 0);
        chk("rst_rdata", rdat[1], 0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | wvld[1];
        end
        chk("rst_no_late_valid", seen, 0);
        txn(1, 1'b0, 32'h20, 4'hF, 32'h0, rd, er);
        chk("rst_old_contents", rd, 32'h01020304);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
